// File: rtl/pid_stream_driver_pkg.sv
// Shared global parameters, FSM state encodings and types for the PID stream driver.
`ifndef PID_GLOBAL_PARAMETER_SVH
`define PID_GLOBAL_PARAMETER_SVH
`define EXTENDED_SINGLE 64
`define N_WindTurbine 4
`define IDLE 3'd0
`define PRE 3'd1
`define SEND 3'd2
`define WAIT 3'd3
`define COLL 3'd4
`define DONE 3'd5
`define ERR 3'd6
`endif

package pid_stream_driver_pkg;
  localparam int unsigned DW   = `EXTENDED_SINGLE;
  localparam int unsigned N_WT = `N_WindTurbine;

  typedef enum logic [2:0] {
    S_IDLE = `IDLE,
    S_PRE  = `PRE,
    S_SEND = `SEND,
    S_WAIT = `WAIT,
    S_COLL = `COLL,
    S_DONE = `DONE,
    S_ERR  = `ERR
  } state_t;
endpackage

// File: rtl/pid_stream_driver_burst_counter.sv
// Loadable down-counter; tc_c marks the last enabled cycle of a loaded burst.
module pid_burst_counter #(
  parameter int unsigned CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc_c
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_c = en && (cnt_q == CW'(1));
endmodule

// File: rtl/pid_stream_driver.sv
// Per-step strobe sequencer: streams N_CH source samples into the PID stage
// and collects its N_CH outputs into the result memory.
module pid_stream_driver
  import pid_stream_driver_pkg::*;
#(
  parameter int unsigned N_CH      = N_WT,
  parameter int unsigned READ_LEAD = 10,
  parameter int unsigned STAGE_LAT = 20,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned AW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_req,
  input  logic          init_req,
  output logic          src_rd,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  output logic          done_read,
  output logic          sta,
  output logic          control_valuation_sig,
  output logic [DW-1:0] x,
  input  logic          done_sig,
  input  logic [DW-1:0] y,
  output logic          res_we,
  output logic [AW-1:0] res_addr,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic          step_done,
  output logic          err_timeout
);
  localparam int unsigned CW = AW + 1;
  // A stage answering at its nominal latency must never be timed out.
  localparam int unsigned TMO_LOAD = (TIMEOUT > STAGE_LAT) ? TIMEOUT : STAGE_LAT + 1;

  state_t        state_q, state_d;
  logic          done_read_q, done_read_d;
  logic          sta_q, sta_d;
  logic          cvs_q, cvs_d;
  logic          src_rd_q, src_rd_d;
  logic [AW-1:0] src_addr_q, src_addr_d;
  logic [DW-1:0] x_q, x_d;
  logic          res_we_q, res_we_d;
  logic [AW-1:0] res_addr_q, res_addr_d;
  logic          busy_q, busy_d;
  logic          step_done_q, step_done_d;
  logic          err_q, err_d;
  logic          init_pend_q, init_pend_d;
  logic          init_snap_q, init_snap_d;

  logic lead_ld, lead_en, lead_tc;
  logic send_ld, send_en, send_tc;
  logic tmo_ld, tmo_en, tmo_tc;
  logic coll_ld, coll_en, coll_tc;

  pid_burst_counter #(.CW(CW)) u_lead_cnt (
    .clk(clk), .rst(rst), .load(lead_ld), .load_val(CW'(READ_LEAD)), .en(lead_en), .tc_c(lead_tc)
  );
  pid_burst_counter #(.CW(CW)) u_send_cnt (
    .clk(clk), .rst(rst), .load(send_ld), .load_val(CW'(N_CH)), .en(send_en), .tc_c(send_tc)
  );
  pid_burst_counter #(.CW(CW)) u_tmo_cnt (
    .clk(clk), .rst(rst), .load(tmo_ld), .load_val(CW'(TMO_LOAD)), .en(tmo_en), .tc_c(tmo_tc)
  );
  pid_burst_counter #(.CW(CW)) u_coll_cnt (
    .clk(clk), .rst(rst), .load(coll_ld), .load_val(CW'(N_CH)), .en(coll_en), .tc_c(coll_tc)
  );

  always_comb begin
    state_d     = state_q;
    done_read_d = 1'b0;
    sta_d       = 1'b0;
    src_rd_d    = 1'b0;
    src_addr_d  = '0;
    res_we_d    = 1'b0;
    res_addr_d  = '0;
    step_done_d = 1'b0;
    err_d       = 1'b0;
    init_pend_d = init_pend_q;
    init_snap_d = init_snap_q;
    lead_ld     = 1'b0;
    send_ld     = 1'b0;
    tmo_ld      = 1'b0;
    coll_ld     = 1'b0;
    lead_en     = (state_q == S_PRE);
    send_en     = (state_q == S_SEND);
    tmo_en      = (state_q == S_SEND) || (state_q == S_WAIT);
    coll_en     = (state_q == S_COLL);
    // Marker stays up until the last streamed sample has left x.
    cvs_d       = cvs_q & src_rd_q;
    x_d         = src_rd_q ? src_data : '0;

    case (state_q)
      S_IDLE: begin
        if (step_req) begin
          state_d     = S_PRE;
          done_read_d = 1'b1;
          lead_ld     = 1'b1;
          init_snap_d = init_pend_q | init_req;
        end
      end
      S_PRE: begin
        if (lead_tc) begin
          state_d     = S_SEND;
          sta_d       = 1'b1;
          src_rd_d    = 1'b1;
          send_ld     = 1'b1;
          tmo_ld      = 1'b1;
          cvs_d       = init_pend_q;
          init_pend_d = 1'b0;
        end
      end
      S_SEND: begin
        if (!send_tc) begin
          src_rd_d   = 1'b1;
          src_addr_d = src_addr_q + AW'(1);
        end else if (done_sig) begin
          state_d  = S_COLL;
          res_we_d = 1'b1;
          coll_ld  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_sig) begin
          state_d  = S_COLL;
          res_we_d = 1'b1;
          coll_ld  = 1'b1;
        end else if (tmo_tc) begin
          state_d     = S_ERR;
          err_d       = 1'b1;
          init_pend_d = init_pend_q | init_snap_q;
        end
      end
      S_COLL: begin
        if (coll_tc) begin
          state_d     = S_DONE;
          step_done_d = 1'b1;
        end else begin
          res_we_d   = 1'b1;
          res_addr_d = res_addr_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (init_req) init_pend_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      done_read_q <= 1'b0;
      sta_q       <= 1'b0;
      cvs_q       <= 1'b0;
      src_rd_q    <= 1'b0;
      src_addr_q  <= '0;
      x_q         <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      err_q       <= 1'b0;
      init_pend_q <= 1'b1;
      init_snap_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      done_read_q <= done_read_d;
      sta_q       <= sta_d;
      cvs_q       <= cvs_d;
      src_rd_q    <= src_rd_d;
      src_addr_q  <= src_addr_d;
      x_q         <= x_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      busy_q      <= busy_d;
      step_done_q <= step_done_d;
      err_q       <= err_d;
      init_pend_q <= init_pend_d;
      init_snap_q <= init_snap_d;
    end
  end

  assign done_read             = done_read_q;
  assign sta                   = sta_q;
  assign control_valuation_sig = cvs_q;
  assign src_rd                = src_rd_q;
  assign src_addr              = src_addr_q;
  assign x                     = x_q;
  assign res_we                = res_we_q;
  assign res_addr              = res_addr_q;
  // y arrives in the write cycle itself, so data is forwarded under the registered enable.
  assign res_data              = res_we_q ? y : '0;
  assign busy                  = busy_q;
  assign step_done             = step_done_q;
  assign err_timeout           = err_q;
endmodule

// File: doc/pid_stream_driver.md
Name: pid_stream_driver

Overview:
- Time-multiplexed stimulus/collection front end for the 64-bit discrete PID/transfer-function stage that holds one filter state per wind turbine.
- Per simulation step it issues the stage's control strobes (done_read, sta, control_valuation_sig) and streams N channel inputs from a source memory.
- It then captures the N returned outputs into a result memory and reports step completion or timeout.

Parameters:
- N_CH, `N_WindTurbine: channels per step; min 2.
- READ_LEAD, 10: cycles from done_read pulse to sta pulse.
- STAGE_LAT, 20: cycles from sta to the stage's done_sig.
- TIMEOUT, 64: maximum cycles from sta to done_sig before an error is flagged.
- AW, 6: source/result address width; N_CH <= 2**AW.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active high.
- step_req  in  1  one-cycle request to run one step.
- init_req  in  1  one-cycle request: next step loads initial values.
- src_rd  out  1  source memory read strobe.
- src_addr  out  AW  source address; data returns 1 cycle later.
- src_data  in  `EXTENDED_SINGLE  source sample.
- done_read  out  1  pulse; stage history FIFO read-out starts.
- sta  out  1  pulse; stage input burst starts.
- control_valuation_sig  out  1  initial-value load marker.
- x  out  `EXTENDED_SINGLE  channel input to stage.
- done_sig  in  1  stage output burst marker.
- y  in  `EXTENDED_SINGLE  stage output.
- res_we  out  1  result write enable.
- res_addr  out  AW  result address.
- res_data  out  `EXTENDED_SINGLE  result data.
- busy  out  1  high from step acceptance through DONE/ERR.
- step_done  out  1  pulse; step completed.
- err_timeout  out  1  pulse; done_sig missing.

Behaviour:
- Reset: all outputs 0; FSM IDLE; init_pend=1, so the first step after reset is an init step.
- init_req sets init_pend in any state. init_pend clears when sta is issued with control_valuation_sig=1.
- IDLE: step_req -> PRE. done_read pulses in the first PRE cycle (D). busy=1.
- step_req outside IDLE is ignored and not queued.
- PRE: counts READ_LEAD cycles. sta pulses in cycle T=D+READ_LEAD, then -> SEND.
- control_valuation_sig = init_pend, held from T through the last x cycle.
- SEND: src_rd=1, src_addr=k in cycle T+k for k=0..N_CH-1. x=src_data registered, so x[k] is valid in cycle T+1+k; otherwise x=0.
- WAIT: done_sig is monitored from T+1.
  - done_sig arriving at cycle R -> COLL.
  - A mismatch R != T+STAGE_LAT is still accepted.
  - If T+TIMEOUT passes with no done_sig -> ERR.
- COLL: y sampled in cycles R+1+k. res_we=1, res_addr=k, res_data=y in the same cycle, k=0..N_CH-1. Then -> DONE.
- DONE: step_done=1 for one cycle, busy=0 next cycle, -> IDLE.
- ERR: err_timeout=1 for one cycle, no result writes, -> IDLE. init_pend is restored to its value at step start.
- done_sig outside WAIT is ignored. If done_sig overlaps the last SEND cycle, it is honored (WAIT is entered early).
- Counters are AW+1 bits wide; address wrap never occurs because N_CH <= 2**AW.
- Async reset mid-step aborts immediately: no further strobes; a partial result write is not completed.

Decomposition:
- Shared global_parameter include: `EXTENDED_SINGLE, `N_WindTurbine, FSM state encodings (IDLE, PRE, SEND, WAIT, COLL, DONE, ERR) as `define constants.
- One sub-module: pid_burst_counter (load/enable/terminal-count pulse). It is instantiated for the lead, send, timeout and collect counts.

Test Plan:
- Reset then step_req at cycle 5 (N_CH=4): done_read@6, sta@16 with control_valuation_sig=1; src_addr 0..3 @16..19; x=src[k] @17..20.
- Stage model returns done_sig @36, y=100+k @37..40 -> res_we @37..40, addr 0..3, data 100..103; step_done @41; second step has control_valuation_sig=0.
- No done_sig within TIMEOUT=64 of sta -> err_timeout pulse @sta+64, zero res_we, init_pend unchanged; next step again has control_valuation_sig=1.
- step_req pulsed during SEND and WAIT -> ignored; exactly one done_read per accepted step.
- init_req mid-step after an init step -> next step asserts control_valuation_sig=1.
- rst asserted during COLL after 2 writes -> outputs 0 immediately; a subsequent step runs normally from IDLE.
